// File: rtl/lorenzo_window_buffer_pkg.sv
// ============================================================================
//  Module      : lorenzo_window_buffer_pkg
//  Description : Shared constants, types and helpers for the SZ line-history
//                window buffer ahead of the Lorenzo predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lorenzo_window_buffer_pkg;

    // Default sample width and row length used by the SZ front end
    localparam int c_SZ_WIDTH    = 32;
    localparam int c_SZ_ROW_LEN  = 49;

    // Deepest history the window supports (north/north-west rows)
    localparam int c_SZ_HIST_MAX = 3;

    // Row counter saturates at HIST_ROWS, which never exceeds 3
    typedef logic [1:0] row_cnt_t;

    // Width of a column index for a row of row_len samples
    function automatic int col_width(input int row_len);
        return (row_len < 2) ? 1 : $clog2(row_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lorenzo_window_buffer_if.sv
// ============================================================================
//  Module      : lorenzo_window_buffer_if
//  Description : Input sample stream and output window stream of the
//                window buffer, each with valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lorenzo_window_buffer_if
    import lorenzo_window_buffer_pkg::*;
#(
    parameter int WIDTH     = c_SZ_WIDTH,
    parameter int ROW_LEN   = c_SZ_ROW_LEN,
    parameter int HIST_ROWS = 1
) ();

    localparam int c_COL_W = col_width(ROW_LEN);

    // Input sample stream
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_data;
    logic                       in_sof;

    // Output window stream
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_cur;
    logic [WIDTH-1:0]           out_west;
    logic [HIST_ROWS*WIDTH-1:0] out_north;
    logic [HIST_ROWS*WIDTH-1:0] out_nwest;
    logic [c_COL_W-1:0]         out_col;
    logic                       out_eol;

    // Window buffer side
    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_cur, out_west,
               out_north, out_nwest, out_col, out_eol
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_cur, out_west,
               out_north, out_nwest, out_col, out_eol
    );

endinterface

`default_nettype wire

// File: rtl/lorenzo_window_buffer_row_delay.sv
// ============================================================================
//  Module      : lorenzo_window_buffer_row_delay
//  Description : Enable-gated ROW_LEN-deep delay line. The tap is the word
//                written exactly ROW_LEN enables ago (read-before-write), and
//                tap_prev holds the tap seen at the previous enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lorenzo_window_buffer_row_delay
    import lorenzo_window_buffer_pkg::*;
#(
    parameter int WIDTH   = c_SZ_WIDTH,
    parameter int ROW_LEN = c_SZ_ROW_LEN
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] tap,
    output logic      [WIDTH-1:0] tap_prev
);

    localparam int c_ADDR_W = col_width(ROW_LEN);

    logic [WIDTH-1:0]    r_mem [ROW_LEN];
    logic [c_ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]    r_tap_prev;

    // Oldest word sits at the write pointer, so read it before it is replaced
    assign tap      = r_mem[r_addr];
    assign tap_prev = r_tap_prev;

    // Storage array; contents are masked downstream until valid, so no reset
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_addr] <= din;
        end
    end

    // Circular write pointer and the one-column-behind tap register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_tap_prev <= '0;
        end else if (en) begin
            r_tap_prev <= tap;
            if (r_addr == c_ADDR_W'(ROW_LEN - 1)) begin
                r_addr <= '0;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lorenzo_window_buffer.sv
// ============================================================================
//  Module      : lorenzo_window_buffer
//  Description : Raster-order line-history buffer. Emits each sample with its
//                west, north and north-west neighbours from up to HIST_ROWS
//                previous rows, zero-padded at frame edges, behind a single
//                valid/ready output register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lorenzo_window_buffer
    import lorenzo_window_buffer_pkg::*;
#(
    parameter int WIDTH     = c_SZ_WIDTH,
    parameter int ROW_LEN   = c_SZ_ROW_LEN,
    parameter int HIST_ROWS = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    lorenzo_window_buffer_if.slave bus
);

    localparam int c_COL_W = col_width(ROW_LEN);

    // Handshake
    logic                       w_in_fire;
    logic                       r_out_valid;

    // Position tracking
    logic [c_COL_W-1:0]         r_col;
    row_cnt_t                   r_row;
    logic [c_COL_W-1:0]         w_col_eff;
    row_cnt_t                   w_row_eff;
    logic                       w_col_last;

    // History
    logic [WIDTH-1:0]           r_west;
    logic [WIDTH-1:0]           w_line_din  [HIST_ROWS];
    logic [WIDTH-1:0]           w_tap       [HIST_ROWS];
    logic [WIDTH-1:0]           w_tap_prev  [HIST_ROWS];
    logic [HIST_ROWS*WIDTH-1:0] w_north;
    logic [HIST_ROWS*WIDTH-1:0] w_nwest;
    logic [WIDTH-1:0]           w_west;

    // Output register stage
    logic [WIDTH-1:0]           r_out_cur;
    logic [WIDTH-1:0]           r_out_west;
    logic [HIST_ROWS*WIDTH-1:0] r_out_north;
    logic [HIST_ROWS*WIDTH-1:0] r_out_nwest;
    logic [c_COL_W-1:0]         r_out_col;
    logic                       r_out_eol;

    // Accept whenever the output register is empty or being drained
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_in_fire    = bus.in_valid && bus.in_ready;

    // Start-of-frame restarts position for the sample that carries it
    assign w_col_eff  = bus.in_sof ? '0 : r_col;
    assign w_row_eff  = bus.in_sof ? '0 : r_row;
    assign w_col_last = (w_col_eff == c_COL_W'(ROW_LEN - 1));

    // Column and saturating row counters advance only on accepted samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_fire) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (w_row_eff == row_cnt_t'(HIST_ROWS)) ? w_row_eff
                                                               : w_row_eff + 1'b1;
            end else begin
                r_col <= w_col_eff + 1'b1;
                r_row <= w_row_eff;
            end
        end
    end

    // Last accepted sample, used as the west neighbour of the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_west <= '0;
        end else if (w_in_fire) begin
            r_west <= bus.in_data;
        end
    end

    // Cascaded row delay lines: line k looks k+1 rows up
    for (genvar k = 0; k < HIST_ROWS; k++) begin : g_line
        if (k == 0) begin : g_head
            assign w_line_din[k] = bus.in_data;
        end else begin : g_chain
            assign w_line_din[k] = w_tap[k-1];
        end

        lorenzo_window_buffer_row_delay #(
            .WIDTH   (WIDTH),
            .ROW_LEN (ROW_LEN)
        ) u_row_delay (
            .clk      (clk),
            .rst      (rst),
            .en       (w_in_fire),
            .din      (w_line_din[k]),
            .tap      (w_tap[k]),
            .tap_prev (w_tap_prev[k])
        );

        // Rows that do not exist yet in this frame read as zero
        assign w_north[k*WIDTH +: WIDTH] = (w_row_eff > row_cnt_t'(k))
                                         ? w_tap[k] : '0;
        assign w_nwest[k*WIDTH +: WIDTH] = (w_row_eff > row_cnt_t'(k) && w_col_eff != '0)
                                         ? w_tap_prev[k] : '0;
    end

    assign w_west = (w_col_eff == '0) ? '0 : r_west;

    // Output window register: load on accept, hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_cur   <= '0;
            r_out_west  <= '0;
            r_out_north <= '0;
            r_out_nwest <= '0;
            r_out_col   <= '0;
            r_out_eol   <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_cur   <= bus.in_data;
            r_out_west  <= w_west;
            r_out_north <= w_north;
            r_out_nwest <= w_nwest;
            r_out_col   <= w_col_eff;
            r_out_eol   <= w_col_last;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_cur   = r_out_cur;
    assign bus.out_west  = r_out_west;
    assign bus.out_north = r_out_north;
    assign bus.out_nwest = r_out_nwest;
    assign bus.out_col   = r_out_col;
    assign bus.out_eol   = r_out_eol;

endmodule

`default_nettype wire

// File: tb/tb_lorenzo_window_buffer.sv
// ============================================================================
//  Module      : tb_lorenzo_window_buffer
//  Description : Directed self-checking bench for lorenzo_window_buffer with
//                WIDTH=8, ROW_LEN=4, HIST_ROWS=2 and a 1,2,3,... stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lorenzo_window_buffer;

    localparam int c_WIDTH = 8;
    localparam int c_ROW   = 4;
    localparam int c_HIST  = 2;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // Windows captured on output transfers, indexed by the sample value
    int         rec_cnt   [256];
    logic [7:0] rec_west  [256];
    logic [7:0] rec_n0    [256];
    logic [7:0] rec_nw0   [256];
    logic [7:0] rec_n1    [256];
    logic [7:0] rec_nw1   [256];
    logic [7:0] rec_col   [256];
    logic       rec_eol   [256];

    lorenzo_window_buffer_if #(
        .WIDTH     (c_WIDTH),
        .ROW_LEN   (c_ROW),
        .HIST_ROWS (c_HIST)
    ) bus ();

    lorenzo_window_buffer #(
        .WIDTH     (c_WIDTH),
        .ROW_LEN   (c_ROW),
        .HIST_ROWS (c_HIST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one sample and wait until it is accepted
    task automatic send(input logic [7:0] d, input logic sof, output int cyc);
        logic acc;
        cyc = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc && cyc < 50);
        check_eq($sformatf("accept_%0d", d), 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    // Check a captured window against hand-computed neighbours
    task automatic check_win(input int v, input int west, input int n0, input int nw0,
                             input int n1, input int nw1, input int col, input int eol);
        check_eq($sformatf("s%0d_west", v), 32'(rec_west[v]), 32'(west));
        check_eq($sformatf("s%0d_n0",   v), 32'(rec_n0[v]),   32'(n0));
        check_eq($sformatf("s%0d_nw0",  v), 32'(rec_nw0[v]),  32'(nw0));
        check_eq($sformatf("s%0d_n1",   v), 32'(rec_n1[v]),   32'(n1));
        check_eq($sformatf("s%0d_nw1",  v), 32'(rec_nw1[v]),  32'(nw1));
        check_eq($sformatf("s%0d_col",  v), 32'(rec_col[v]),  32'(col));
        check_eq($sformatf("s%0d_eol",  v), 32'(rec_eol[v]),  32'(eol));
    endtask

    // Capture every window that transfers on the following rising edge
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            rec_cnt [bus.out_cur] <= rec_cnt[bus.out_cur] + 1;
            rec_west[bus.out_cur] <= bus.out_west;
            rec_n0  [bus.out_cur] <= bus.out_north[7:0];
            rec_nw0 [bus.out_cur] <= bus.out_nwest[7:0];
            rec_n1  [bus.out_cur] <= bus.out_north[15:8];
            rec_nw1 [bus.out_cur] <= bus.out_nwest[15:8];
            rec_col [bus.out_cur] <= 8'(bus.out_col);
            rec_eol [bus.out_cur] <= bus.out_eol;
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) rec_cnt[i] = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_cur",   32'(bus.out_cur),   32'd0);
        check_eq("rst_out_col",   32'(bus.out_col),   32'd0);
        check_eq("rst_out_eol",   32'(bus.out_eol),   32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Continuous stream up to sample 7
        for (int v = 1; v <= 7; v++) begin
            send(8'(v), v == 1, cyc);
        end

        // Downstream stall with sample 7 on the output and 8 pending
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(bus.out_valid),        32'd1);
            check_eq("stall_cur",   32'(bus.out_cur),          32'd7);
            check_eq("stall_west",  32'(bus.out_west),         32'd6);
            check_eq("stall_n0",    32'(bus.out_north[7:0]),   32'd3);
            check_eq("stall_nw0",   32'(bus.out_nwest[7:0]),   32'd2);
            check_eq("stall_ready", 32'(bus.in_ready),         32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;

        for (int v = 8; v <= 13; v++) begin
            send(8'(v), 1'b0, cyc);
            if (v == 10) check_eq("throughput_10", 32'(cyc), 32'd1);
        end

        // New frame starting mid-row
        send(8'd14, 1'b1, cyc);
        for (int v = 15; v <= 20; v++) begin
            send(8'(v), 1'b0, cyc);
        end

        // Asynchronous reset while sample 20 sits on the output
        #2 rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_out_cur",   32'(bus.out_cur),   32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        send(8'd21, 1'b0, cyc);
        repeat (3) @(posedge clk);
        #1;

        // Each sample transferred exactly once; 20 was flushed by reset
        for (int v = 1; v <= 19; v++) begin
            check_eq($sformatf("count_s%0d", v), 32'(rec_cnt[v]), 32'd1);
        end
        check_eq("count_s20", 32'(rec_cnt[20]), 32'd0);
        check_eq("count_s21", 32'(rec_cnt[21]), 32'd1);

        //        v   west n0 nw0 n1 nw1 col eol
        check_win(1,  0,   0, 0,  0, 0,  0,  0);
        check_win(4,  3,   0, 0,  0, 0,  3,  1);
        check_win(6,  5,   2, 1,  0, 0,  1,  0);
        check_win(7,  6,   3, 2,  0, 0,  2,  0);
        check_win(8,  7,   4, 3,  0, 0,  3,  1);
        check_win(9,  0,   5, 0,  1, 0,  0,  0);
        check_win(11, 10,  7, 6,  3, 2,  2,  0);
        check_win(13, 0,   9, 0,  5, 0,  0,  0);
        check_win(14, 0,   0, 0,  0, 0,  0,  0);
        check_win(15, 14,  0, 0,  0, 0,  1,  0);
        check_win(18, 0,  14, 0,  0, 0,  0,  0);
        check_win(19, 18, 15, 14, 0, 0,  1,  0);
        check_win(21, 0,   0, 0,  0, 0,  0,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lorenzo_window_buffer.md
# lorenzo_window_buffer

Parametrised line-history buffer for the SZ prediction front end. It accepts one sample per handshake in raster order and emits each sample together with its causal neighbourhood: west, plus north and north-west from up to HIST_ROWS previous rows, zero-padded at frame edges. It replaces the fixed 4-deep, move-strobed row buffer ahead of the Lorenzo predictor. Row length is a parameter rather than an external strobe, and the block adds valid/ready flow control.

## Interface
- WIDTH, 32: sample width in bits.
- ROW_LEN, 49: samples per row; must be ≥2.
- HIST_ROWS, 1: previous rows retained; legal range 1..3.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  sample, raster order.
- in_sof  in  1  the sample is row 0, column 0 of a new frame.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_cur  out  WIDTH  current sample.
- out_west  out  WIDTH  previous sample in the same row, or 0.
- out_north  out  HIST_ROWS*WIDTH  slice k is the same column k+1 rows up, or 0.
- out_nwest  out  HIST_ROWS*WIDTH  slice k is column-1, k+1 rows up, or 0.
- out_col  out  $clog2(ROW_LEN)  column of out_cur.
- out_eol  out  1  out_cur is the last sample of its row.

## Operation
- A transfer on either side occurs on a cycle where valid and ready are both high.
- in_ready = !out_valid || out_ready. This is a single output register stage with no bubble under continuous flow.
- col counter:
  - Advances on each accepted input and wraps from ROW_LEN-1 to 0.
  - On wrap, row_cnt increments, saturating at HIST_ROWS.
- in_sof on an accepted sample forces col=0 and row_cnt=0 for that sample, then counting resumes. in_sof is ignored when no transfer occurs.
- History store: HIST_ROWS cascaded row delay lines of ROW_LEN words each.
  - Line 0 takes in_data on accept.
  - Line k takes line k-1's output on accept.
  - A separate west register holds the last accepted sample.
  - Line k's output is the sample k+1 rows up at the current column. The register after it holds column-1.
- Per accepted sample, the block registers:
  - out_cur = in_data.
  - out_west = col==0 ? 0 : west register.
  - out_north[k] = row_cnt>k ? line k tap : 0.
  - out_nwest[k] = (row_cnt>k && col>0) ? line k tap-1 : 0.
  - out_col = col.
  - out_eol = (col==ROW_LEN-1).
- Padding is done by masking only; stored history is never cleared by in_sof.
- Nothing shifts or updates while no input is accepted. A stall freezes all state.

## Timing
- Latency: 1 cycle from input accept to out_valid high.
- Throughput: 1 sample per cycle with out_ready held high.
- Reset (rst low, asynchronous):
  - out_valid=0 and all output data/col/eol = 0.
  - col=0, row_cnt=0.
  - History contents are don't-care: they are masked until row_cnt rises.
- Release of reset is synchronous to clk.
- out_valid stays high until accepted. While out_valid && !out_ready, all out_* signals remain stable.
- A simultaneous output accept and input accept in one cycle loads the new window. out_valid remains 1.
- in_sof arriving mid-row truncates the old row. The new frame starts padded on the very next window.
- ROW_LEN wrap and in_sof in the same cycle: in_sof wins.
- Reset asserted mid-frame: the next sample is treated as row 0, column 0 regardless of in_sof.

## Structure
- Shared package sz_pkg (or include) holds:
  - default SZ_WIDTH=32 and SZ_ROW_LEN=49;
  - the HIST_ROWS limit of 3;
  - the helper for computing column width.
- One sub-module, sz_row_delay:
  - a ROW_LEN×WIDTH enable-gated delay line with tap output and tap-1 register;
  - instantiated HIST_ROWS times by generate;
  - may map to inferred RAM with a read-before-write address counter.
- Top level holds the counters, masking, and output register stage.

## Test plan
Configuration for all scenarios: WIDTH=8, ROW_LEN=4, HIST_ROWS=2. Input stream is 1,2,3,… with in_sof on the first sample.
- Reset then continuous stream, out_ready=1:
  - sample 1 → west=0, north=0, nwest=0, col=0;
  - sample 4 → eol=1, west=3.
- Sample 6 (row 1, col 1) → west=5, north[0]=2, nwest[0]=1, north[1]=0, nwest[1]=0.
- Sample 11 (row 2, col 2) → west=10, north[0]=7, nwest[0]=6, north[1]=3, nwest[1]=2. Sample 9 → west=0, nwest=0, north[0]=5, north[1]=1.
- out_ready low for 5 cycles at sample 7:
  - outputs hold 7's window stable;
  - in_ready=0;
  - after release, sample 8 follows with correct neighbours and no loss or duplication.
- in_sof asserted on sample 14 (mid-row) → window for 14 is all-zero neighbours, col=0; sample 18 sees north[0]=14.
- rst pulsed low asynchronously mid-row → out_valid drops immediately. The next accepted sample (no sof) reports col=0 with zero neighbours.
